// File: rtl/mfp_eic_input_filter_pkg.sv
// Shared encodings and defaults for the EIC input conditioning block.
package mfp_eic_input_filter_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_CHK_HIGH = 2'd1,
    S_HIGH     = 2'd2,
    S_CHK_LOW  = 2'd3
  } deb_state_e;

  localparam int DEF_CHANNELS        = 8;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mfp_eic_filter_channel.sv
// One interrupt channel: synchronizer, debounce FSM and rising-edge detect.
module mfp_eic_filter_channel
  import mfp_eic_input_filter_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic level_i,
  output logic s_o,
  output logic filt_o,
  output logic rise_o
);

  localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  deb_state_e             state_q;
  logic [CW-1:0]          cnt_q;
  logic                   filt_q;
  logic                   prev_q;
  logic                   s;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
  end

  assign s = sync_q[SYNC_STAGES-1];

  // The counter tracks consecutive samples at the new level; a single
  // sample back at the old level drops back to the settled state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      filt_q  <= 1'b0;
    end else begin
      case (state_q)
        S_LOW: if (s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_q <= S_HIGH;
            filt_q  <= 1'b1;
          end else begin
            state_q <= S_CHK_HIGH;
            cnt_q   <= CNT_ONE;
          end
        end
        S_CHK_HIGH: begin
          if (!s) begin
            state_q <= S_LOW;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_HIGH;
            filt_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        S_HIGH: if (!s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            state_q <= S_LOW;
            filt_q  <= 1'b0;
          end else begin
            state_q <= S_CHK_LOW;
            cnt_q   <= CNT_ONE;
          end
        end
        S_CHK_LOW: begin
          if (s) begin
            state_q <= S_HIGH;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_LOW;
            filt_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= S_LOW;
          cnt_q   <= '0;
          filt_q  <= 1'b0;
        end
      endcase
    end
  end

  // level_i is the post-bypass EIC level, so bypass toggles also pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) prev_q <= 1'b0;
    else         prev_q <= level_i;
  end

  assign s_o    = s;
  assign filt_o = filt_q;
  assign rise_o = level_i & ~prev_q;

endmodule

// File: rtl/mfp_eic_input_filter.sv
// Conditions raw external interrupt lines before they reach EIC_input.
module mfp_eic_input_filter
  import mfp_eic_input_filter_pkg::*;
#(
  parameter int CHANNELS        = DEF_CHANNELS,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [CHANNELS-1:0] raw_irq,
  input  logic [CHANNELS-1:0] bypass,
  output logic [CHANNELS-1:0] EIC_input,
  output logic [CHANNELS-1:0] irq_rise
);

  logic [CHANNELS-1:0] s_vec;
  logic [CHANNELS-1:0] filt_vec;

  assign EIC_input = (bypass & s_vec) | (~bypass & filt_vec);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    mfp_eic_filter_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk_i  (HCLK),
      .rst_ni (HRESETn),
      .raw_i  (raw_irq[i]),
      .level_i(EIC_input[i]),
      .s_o    (s_vec[i]),
      .filt_o (filt_vec[i]),
      .rise_o (irq_rise[i])
    );
  end

endmodule

// File: tb/tb_mfp_eic_input_filter.sv
// Scoreboard bench: D=4 and D=1 instances share stimulus; a run-length model predicts outputs.
module tb_mfp_eic_input_filter;

  localparam int CH = 8;
  localparam int SS = 2;

  logic          HCLK;
  logic          HRESETn;
  logic [CH-1:0] raw_irq;
  logic [CH-1:0] bypass;
  logic [CH-1:0] eic4, rise4, eic1, rise1;

  mfp_eic_input_filter #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(4)) u_dut4 (
    .HCLK(HCLK), .HRESETn(HRESETn), .raw_irq(raw_irq), .bypass(bypass),
    .EIC_input(eic4), .irq_rise(rise4)
  );

  mfp_eic_input_filter #(.CHANNELS(CH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(1)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .raw_irq(raw_irq), .bypass(bypass),
    .EIC_input(eic1), .irq_rise(rise1)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  typedef struct packed {
    logic [CH-1:0] eic4;
    logic [CH-1:0] rise4;
    logic [CH-1:0] eic1;
    logic [CH-1:0] rise1;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Model: delay line for the synchronizer, and a run length of samples
  // that disagree with the filtered level; D such samples flip the level.
  bit m_sync [2][CH][SS];
  int m_run  [2][CH];
  bit m_filt [2][CH];
  bit m_prev [2][CH];
  int m_d    [2] = '{4, 1};

  task automatic step(input logic [CH-1:0] raw, input logic [CH-1:0] byp, input logic rst);
    exp_t e;
    logic [CH-1:0] ev [2];
    logic [CH-1:0] rv [2];
    @(negedge HCLK);
    raw_irq = raw;
    bypass  = byp;
    HRESETn = rst;
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < CH; c++) begin
        if (!rst) begin
          for (int k = 0; k < SS; k++) m_sync[n][c][k] = 1'b0;
          m_run[n][c]  = 0;
          m_filt[n][c] = 1'b0;
          m_prev[n][c] = 1'b0;
          ev[n][c] = 1'b0;
          rv[n][c] = 1'b0;
        end else begin
          bit s_old, lvl_old;
          s_old   = m_sync[n][c][SS-1];
          lvl_old = byp[c] ? s_old : m_filt[n][c];
          if (s_old != m_filt[n][c]) begin
            m_run[n][c]++;
            if (m_run[n][c] >= m_d[n]) begin
              m_filt[n][c] = s_old;
              m_run[n][c]  = 0;
            end
          end else begin
            m_run[n][c] = 0;
          end
          for (int k = SS - 1; k > 0; k--) m_sync[n][c][k] = m_sync[n][c][k-1];
          m_sync[n][c][0] = raw[c];
          m_prev[n][c] = lvl_old;
          ev[n][c] = byp[c] ? m_sync[n][c][SS-1] : m_filt[n][c];
          rv[n][c] = ev[n][c] & ~m_prev[n][c];
        end
      end
    end
    e.eic4 = ev[0]; e.rise4 = rv[0]; e.eic1 = ev[1]; e.rise1 = rv[1];
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [CH-1:0] got, input logic [CH-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Monitor: every edge after a stimulus step yields one expected record.
  initial begin
    exp_t e;
    forever begin
      @(posedge HCLK);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("eic_d4",  eic4,  e.eic4);
        cmp("rise_d4", rise4, e.rise4);
        cmp("eic_d1",  eic1,  e.eic1);
        cmp("rise_d1", rise1, e.rise1);
      end
    end
  end

  initial begin
    logic [CH-1:0] r, b;
    HRESETn = 1'b0;
    raw_irq = '0;
    bypass  = '0;

    repeat (3) step(8'hFF, 8'h00, 1'b0);
    // Absolute latency after release, independent of the model.
    for (int i = 1; i <= 7; i++) begin
      step(8'hFF, 8'h00, 1'b1);
      @(posedge HCLK);
      #1;
      cmp("lat_eic_d4",  eic4,  (i >= 6) ? 8'hFF : 8'h00);
      cmp("lat_rise_d4", rise4, (i == 6) ? 8'hFF : 8'h00);
      cmp("lat_eic_d1",  eic1,  (i >= 3) ? 8'hFF : 8'h00);
      cmp("lat_rise_d1", rise1, (i == 3) ? 8'hFF : 8'h00);
    end
    repeat (8) step(8'h00, 8'h00, 1'b1);

    repeat (3)  step(8'h08, 8'h00, 1'b1);
    repeat (10) step(8'h00, 8'h00, 1'b1);
    repeat (4)  step(8'h08, 8'h00, 1'b1);
    repeat (10) step(8'h00, 8'h00, 1'b1);

    repeat (8)  step(8'h02, 8'h00, 1'b1);
    repeat (2)  step(8'h00, 8'h00, 1'b1);
    repeat (10) step(8'h02, 8'h00, 1'b1);
    repeat (8)  step(8'h00, 8'h00, 1'b1);

    step(8'h20, 8'h20, 1'b1);
    repeat (6) step(8'h00, 8'h20, 1'b1);
    step(8'h20, 8'h00, 1'b1);
    repeat (6) step(8'h00, 8'h00, 1'b1);

    repeat (4)  step(8'h01, 8'h00, 1'b1);
    step(8'h01, 8'h00, 1'b0);
    repeat (10) step(8'h01, 8'h00, 1'b1);
    repeat (8)  step(8'h00, 8'h00, 1'b1);

    // Alternate channels in opposite phase.
    for (int i = 0; i < 12; i++) step((i % 3 == 0) ? 8'h55 : 8'hAA, 8'h00, 1'b1);
    // Toggle every cycle: D=4 output must stay low.
    for (int i = 0; i < 12; i++) step((i % 2 == 0) ? 8'hFF : 8'h00, 8'h00, 1'b1);

    r = '0;
    b = '0;
    for (int i = 0; i < 3000; i++) begin
      if ((i / 200) % 4 == 3) r = r ^ CH'($urandom);
      else                    r = r ^ CH'($urandom & $urandom & $urandom);
      if ($urandom_range(31) == 0) b = CH'($urandom);
      step(r, b, ($urandom_range(150) != 0));
    end
    repeat (4) step(8'h00, 8'h00, 1'b1);
    repeat (3) @(posedge HCLK);
    #2;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mfp_eic_input_filter.md
Name: mfp_eic_input_filter

Overview:
- Conditions raw external interrupt lines before they reach the EIC core's EIC_input bus.
- Per channel, three stages in order:
  - SYNC_STAGES-deep synchronizer, for asynchronous pins.
  - Debounce FSM: the output changes only after the synchronized input holds a new value for DEBOUNCE_CYCLES consecutive cycles.
  - One-cycle rising-edge event output.
- Sits between board-level interrupt sources (buttons, timers, GPIO) and the EIC; clocked by the AHB-Lite clock.

Parameters:
- CHANNELS, 8: number of interrupt channels; must equal the EIC channel count (EIC_CHANNELS) at instantiation.
- SYNC_STAGES, 2: synchronizer flops per channel; legal range >= 2.
- DEBOUNCE_CYCLES, 4: consecutive stable samples required to change the output; legal range >= 1; 1 = no filtering.

Ports:
- HCLK  in  1  clock; all logic on posedge.
- HRESETn  in  1  reset, synchronous, active-low.
- raw_irq  in  CHANNELS  asynchronous raw interrupt lines.
- bypass  in  CHANNELS  per-channel: 1 = output follows the synchronized input, debounce skipped; quasi-static.
- EIC_input  out  CHANNELS  filtered interrupt level; connect to EIC_input of the EIC.
- irq_rise  out  CHANNELS  one-cycle pulse when the EIC_input bit goes 0->1.

Behaviour:
- Single clock HCLK. Reset is synchronous and active-low on HRESETn, sampled only at posedge HCLK.
- Reset values, applied at the first edge with HRESETn=0:
  - all sync flops 0;
  - every FSM in S_LOW;
  - counters 0;
  - EIC_input 0;
  - irq_rise 0.
- Synchronizer:
  - sync[0] <= raw_irq; sync[k] <= sync[k-1].
  - s = last stage.
  - No reset-free flops.
- Debounce FSM per channel: states S_LOW, S_CHK_HIGH, S_HIGH, S_CHK_LOW. Counter width is clog2(DEBOUNCE_CYCLES+1).
  - S_LOW:
    - s=1 and D=1 -> S_HIGH, filt<=1.
    - s=1 and D>1 -> S_CHK_HIGH, cnt<=1.
    - Else stay.
  - S_CHK_HIGH:
    - s=0 -> S_LOW, cnt<=0 (glitch rejected).
    - Else if cnt==D-1 -> S_HIGH, filt<=1, cnt<=0.
    - Else cnt<=cnt+1.
  - S_HIGH / S_CHK_LOW: mirror image of S_LOW / S_CHK_HIGH with the polarity inverted.
  - filt is a register, updated at the same edge as the state transition.
- Latency for a clean raw edge arriving before edge 0:
  - s changes at edge SYNC_STAGES.
  - filt changes at edge SYNC_STAGES+D.
  - Defaults: edge 6.
- Rejection: any s pulse shorter than D cycles (either polarity) never reaches filt.
- Bypass:
  - EIC_input[i] = bypass[i] ? s[i] : filt[i]. This is combinational from registers; there is no combinational path from raw_irq.
  - The FSM keeps running while bypassed, so leaving bypass at most changes the level to the already-debounced value.
- irq_rise:
  - Register prev <= EIC_input; irq_rise = EIC_input & ~prev (derived from registers).
  - Exactly one cycle per 0->1 transition of EIC_input, including transitions caused by toggling bypass.
  - prev resets to 0, so no pulse is produced on reset release while the inputs are low.
- Boundary cases:
  - Counter never exceeds D-1; no wrap-around.
  - s toggling every cycle keeps the FSM alternating S_LOW/S_CHK_HIGH; the output stays 0.
  - Reset mid-operation (counter partway): state and output clear at the next edge. After release, a held-high input needs the full SYNC_STAGES+D edges again.
  - Channels are fully independent; simultaneous events on all channels are allowed.

Decomposition:
- Shared header/package: FSM state encodings (2-bit: S_LOW=0, S_CHK_HIGH=1, S_HIGH=2, S_CHK_LOW=3), parameter defaults, and a clog2 helper constant function.
- Sub-module mfp_eic_filter_channel:
  - one channel: synchronizer + FSM + counter + rise detect;
  - instantiated CHANNELS times with a generate loop.
- The top level only wires vectors and the bypass mux.

Test Plan (all tests use the defaults CHANNELS=8, SYNC_STAGES=2, D=4 unless a line states otherwise; relevant lines use bypass=0):
- Reset / clean rise: hold HRESETn=0 for 3 cycles with raw_irq=8'hFF, then release; raw held high -> EIC_input=0 until 6 edges after the first edge with HRESETn=1 (2 sync + 4 debounce), then 8'hFF; irq_rise=8'hFF for exactly one cycle.
- Glitch rejection: raw_irq[3] high for 3 cycles, then low -> EIC_input[3] stays 0, irq_rise[3] never asserts. Repeat with 4 cycles -> EIC_input[3] rises at edge 6 and falls 6 edges after raw falls.
- Falling glitch: channel 1 stable high; raw low for 2 cycles -> EIC_input[1] stays 1, no irq_rise.
- Bypass: bypass[5]=1, 1-cycle raw pulse on channel 5 -> EIC_input[5] high for exactly 1 cycle, 2 edges after raw, with a matching irq_rise[5]; the same pulse with bypass[5]=0 -> no output.
- Reset mid-count: raw_irq[0] high; HRESETn=0 at edge 4 for one cycle -> EIC_input[0] stays 0, then rises 6 edges after reset release.
- D=1 configuration: a 1-cycle raw pulse passes with 3-edge latency and a 1-cycle width on every channel; independence checked by driving alternate channels with opposite patterns.
